// File: rtl/serial_tx_if.sv
// ============================================================================
//  Module   : serial_tx_if
//  Brief    : Word handshake between a producer and the serial transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

`default_nettype wire

// File: rtl/serial_tx.sv
// ============================================================================
//  Module   : serial_tx
//  Brief    : UART-style framed transmitter (start, DATA_W bits LSB first, stop).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    serial_tx_if.slave  bus,
    output logic        tx_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int c_div_w = $clog2(CLKS_PER_BIT);
    localparam int c_bit_w = $clog2(DATA_W + 1);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLKS_PER_BIT - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [c_div_w-1:0]  div_q,   div_d;
    logic [c_bit_w-1:0]  bit_q,   bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                tx_q,    tx_d;
    logic                done_q,  done_d;

    logic                w_bit_end;

    assign w_bit_end = (div_q == c_div_last);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // tx_d is the line level for the cycle after this edge, so the pin flop
    // lines up exactly with the state it belongs to.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.tx_valid) begin
                    state_d = S_START;
                    shift_d = bus.tx_data;
                    div_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    state_d = S_DATA;
                    div_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    div_d   = div_q + c_div_w'(1);
                    tx_d    = 1'b0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    div_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == c_bit_last) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + c_bit_w'(1);
                        tx_d    = shift_d[0];
                    end
                end else begin
                    div_d   = div_q + c_div_w'(1);
                    tx_d    = shift_q[0];
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    div_d   = div_q + c_div_w'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.tx_ready = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign tx_o         = tx_q;
    assign done_o       = done_q;

endmodule

`default_nettype wire
